// File: rtl/i2c_master_regbus.sv
// rtl/i2c_master_regbus.sv - I2C master issuing 32-bit register writes/reads to the board register slave
//
// Ports:
//   sys_clk_i, rst_i         clock, synchronous active-high reset
//   dev_adr_i                7-bit target device address (latched at accept)
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_rw_i 0=write 1=read
//   cmd_addr_i, cmd_wdata_i  register word address, write data (MSB byte first)
//   rsp_valid_o              one-cycle completion pulse
//   rsp_nack_o, rsp_rdata_o  slave NACK flag and read word, held until next response
//   busy_o                   transaction in progress, including bus-free time
//   SCL, SDA                 open-drain bus lines (driven 0 or released)
module i2c_master_regbus #(
    parameter int CLK_DIV = 250
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic [6:0]  dev_adr_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rw_i,
    input  logic [7:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_nack_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    inout  wire         SCL,
    inout  wire         SDA
);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, TX_ACK, RESTART, RX_BYTE, RX_ACK, STOP, BUF
    } state_t;

    state_t      state, state_next;
    logic [11:0] qcnt;
    logic [1:0]  q;
    logic        qtick, sample, bit_end, scl_bit;
    logic [6:0]  dev_r;
    logic        rw_r, rd_phase, nack_r, ack_r;
    logic [7:0]  addr_r, shift;
    logic [31:0] wdata_r, rdata_r;
    logic [2:0]  bitcnt, bytecnt;
    logic        scl_low, sda_low, scl_low_d, sda_low_d;
    logic [1:0]  sda_s;

    assign qtick   = (qcnt == 12'(CLK_DIV - 1));
    assign sample  = qtick && (q == 2'd2);
    assign bit_end = qtick && (q == 2'd3);
    // Standard bit cell: SCL pulled low in Q3 and Q0, released in Q1/Q2.
    assign scl_bit = (q == 2'd0) || (q == 2'd3);

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    assign SCL = scl_low ? 1'b0 : 1'bz;
    assign SDA = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        scl_low_d  = 1'b0;
        sda_low_d  = 1'b0;
        unique case (state)
            IDLE: if (cmd_valid_i) state_next = START;
            START: begin
                sda_low_d = q[1];
                scl_low_d = (q == 2'd3);
                if (bit_end) state_next = TX_BYTE;
            end
            RESTART: begin
                // SDA released while SCL low in Q0, then a normal START shape.
                sda_low_d = q[1];
                scl_low_d = scl_bit;
                if (bit_end) state_next = TX_BYTE;
            end
            TX_BYTE: begin
                scl_low_d = scl_bit;
                sda_low_d = ~shift[7];
                if (bit_end && bitcnt == 3'd7) state_next = TX_ACK;
            end
            TX_ACK: begin
                scl_low_d = scl_bit;
                if (bit_end) begin
                    if (ack_r)                            state_next = STOP;
                    else if (rd_phase)                    state_next = RX_BYTE;
                    else if (rw_r && bytecnt == 3'd1)     state_next = RESTART;
                    else if (!rw_r && bytecnt == 3'd5)    state_next = STOP;
                    else                                  state_next = TX_BYTE;
                end
            end
            RX_BYTE: begin
                scl_low_d = scl_bit;
                if (bit_end && bitcnt == 3'd7) state_next = RX_ACK;
            end
            RX_ACK: begin
                // ACK the first three bytes, NACK the last so the slave lets go.
                scl_low_d = scl_bit;
                sda_low_d = (bytecnt != 3'd3);
                if (bit_end) state_next = (bytecnt == 3'd3) ? STOP : RX_BYTE;
            end
            STOP: begin
                scl_low_d = (q == 2'd0);
                sda_low_d = (q != 2'd3);
                if (bit_end) state_next = BUF;
            end
            BUF: if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quarter-bit timebase; held at zero while idle so every transaction
    // starts on a fresh quarter.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i || state == IDLE) begin
            qcnt <= '0;
            q    <= 2'd0;
        end else if (qtick) begin
            qcnt <= '0;
            q    <= q + 2'd1;
        end else begin
            qcnt <= qcnt + 12'd1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            scl_low     <= 1'b0;
            sda_low     <= 1'b0;
            sda_s       <= 2'b11;
            dev_r       <= '0;
            rw_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            shift       <= '0;
            bitcnt      <= '0;
            bytecnt     <= '0;
            rd_phase    <= 1'b0;
            nack_r      <= 1'b0;
            ack_r       <= 1'b0;
            rdata_r     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_nack_o  <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            scl_low     <= scl_low_d;
            sda_low     <= sda_low_d;
            sda_s       <= {sda_s[0], SDA};
            rsp_valid_o <= 1'b0;
            unique case (state)
                IDLE: if (cmd_valid_i) begin
                    dev_r    <= dev_adr_i;
                    rw_r     <= cmd_rw_i;
                    addr_r   <= cmd_addr_i;
                    wdata_r  <= cmd_wdata_i;
                    shift    <= {dev_adr_i, 1'b0};
                    bitcnt   <= '0;
                    bytecnt  <= '0;
                    rd_phase <= 1'b0;
                    nack_r   <= 1'b0;
                    rdata_r  <= '0;
                end
                TX_BYTE: if (bit_end) begin
                    shift  <= {shift[6:0], 1'b0};
                    bitcnt <= bitcnt + 3'd1;
                end
                TX_ACK: begin
                    if (sample) ack_r <= sda_s[1];
                    if (bit_end) begin
                        if (ack_r) begin
                            nack_r <= 1'b1;
                        end else if (rd_phase) begin
                            bytecnt <= '0;
                        end else begin
                            bytecnt <= bytecnt + 3'd1;
                            unique case (bytecnt)
                                3'd0:    shift <= addr_r;
                                3'd1:    shift <= wdata_r[31:24];
                                3'd2:    shift <= wdata_r[23:16];
                                3'd3:    shift <= wdata_r[15:8];
                                3'd4:    shift <= wdata_r[7:0];
                                default: shift <= shift;
                            endcase
                        end
                    end
                end
                RESTART: if (bit_end) begin
                    shift    <= {dev_r, 1'b1};
                    rd_phase <= 1'b1;
                end
                RX_BYTE: begin
                    if (sample)  rdata_r <= {rdata_r[30:0], sda_s[1]};
                    if (bit_end) bitcnt  <= bitcnt + 3'd1;
                end
                RX_ACK: if (bit_end) bytecnt <= bytecnt + 3'd1;
                STOP: if (bit_end) begin
                    rsp_valid_o <= 1'b1;
                    rsp_nack_o  <= nack_r;
                    rsp_rdata_o <= (rw_r && !nack_r) ? rdata_r : 32'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_regbus.sv
// tb/tb_i2c_master_regbus.sv - directed self-checking bench for i2c_master_regbus with a register slave model
module tb_i2c_master_regbus;

    localparam int         CLK_DIV = 8;
    localparam logic [6:0] SLV_ADR = 7'h50;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  dev_adr = 7'h50;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid, rsp_nack, busy;
    logic [31:0] rsp_rdata;
    wire         SCL, SDA;

    always #5 sys_clk = ~sys_clk;

    pullup (SCL);
    pullup (SDA);

    logic slv_drive = 1'b0;
    assign SDA = slv_drive ? 1'b0 : 1'bz;

    i2c_master_regbus #(.CLK_DIV(CLK_DIV)) dut (
        .sys_clk_i   (sys_clk),
        .rst_i       (rst),
        .dev_adr_i   (dev_adr),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_rw_i    (cmd_rw),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_nack_o  (rsp_nack),
        .rsp_rdata_o (rsp_rdata),
        .busy_o      (busy),
        .SCL         (SCL),
        .SDA         (SDA)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus edge detection
    logic scl_v, sda_v;
    logic p_scl = 1'b1, p_sda = 1'b1;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_v     = SCL;
    assign sda_v     = SDA;
    assign scl_rise  = scl_v & ~p_scl;
    assign scl_fall  = ~scl_v & p_scl;
    assign start_det = p_scl & scl_v & p_sda & ~sda_v;
    assign stop_det  = p_scl & scl_v & ~p_sda & sda_v;

    // Bus monitor: every 9-bit frame {byte, ack} plus timing statistics
    logic [8:0] mon_q [$];
    logic [7:0] mon_sh = 8'h0;
    int mon_cnt = 0, n_start = 0, n_stop = 0, n_rsp = 0;
    int cyc = 0, edge_cnt = 0, sda_fall_cyc = 0, start_hold = 0;
    int hi_min = 9999, hi_max = 0, lo_min = 9999, lo_max = 0;
    logic stat_en = 1'b0, seen_rise = 1'b0, seen_fall = 1'b0;

    always @(posedge sys_clk) begin
        p_scl    <= scl_v;
        p_sda    <= sda_v;
        cyc      <= cyc + 1;
        edge_cnt <= (scl_rise || scl_fall) ? 1 : edge_cnt + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
        if (start_det) begin
            n_start      <= n_start + 1;
            mon_cnt      <= 0;
            sda_fall_cyc <= cyc;
        end
        if (stop_det) n_stop <= n_stop + 1;
        if (scl_rise) begin
            if (mon_cnt == 8) begin
                mon_q.push_back({mon_sh, sda_v});
                mon_cnt <= 0;
            end else begin
                mon_sh  <= {mon_sh[6:0], sda_v};
                mon_cnt <= mon_cnt + 1;
            end
        end
        if (!stat_en) begin
            seen_rise <= 1'b0;
            seen_fall <= 1'b0;
        end else begin
            if (scl_rise) begin
                seen_rise <= 1'b1;
                if (seen_fall) begin
                    if (edge_cnt < lo_min) lo_min <= edge_cnt;
                    if (edge_cnt > lo_max) lo_max <= edge_cnt;
                end
            end
            if (scl_fall) begin
                seen_fall <= 1'b1;
                if (!seen_fall) start_hold <= cyc - sda_fall_cyc;
                if (seen_rise) begin
                    if (edge_cnt < hi_min) hi_min <= edge_cnt;
                    if (edge_cnt > hi_max) hi_max <= edge_cnt;
                end
            end
        end
    end

    // Register slave model at SLV_ADR
    logic        active = 1'b0, in_ack = 1'b0, tx = 1'b0, rd_go = 1'b0, m_nack = 1'b0;
    logic [3:0]  bitc = 4'd0;
    logic [7:0]  shreg = 8'h0, reg_addr = 8'h0, wr_addr = 8'h0;
    logic [2:0]  byte_idx = 3'd0;
    logic [31:0] wbuf = 32'h0, txsh = 32'h0, wr_data = 32'h0;
    logic [31:0] mem [0:255];
    int          wr_cnt = 0;

    always @(posedge sys_clk) begin
        if (rst) mem[8'h10] <= 32'h12345678;
        if (start_det) begin
            active    <= 1'b1;
            in_ack    <= 1'b0;
            tx        <= 1'b0;
            rd_go     <= 1'b0;
            bitc      <= 4'd0;
            byte_idx  <= 3'd0;
            slv_drive <= 1'b0;
        end else if (stop_det) begin
            active    <= 1'b0;
            tx        <= 1'b0;
            slv_drive <= 1'b0;
        end else if (active) begin
            if (scl_rise) begin
                if (!in_ack) begin
                    if (!tx) shreg <= {shreg[6:0], sda_v};
                    bitc <= bitc + 4'd1;
                end else if (tx) begin
                    m_nack <= sda_v;
                end
            end else if (scl_fall) begin
                if (!in_ack && bitc == 4'd8) begin
                    in_ack <= 1'b1;
                    if (tx) begin
                        slv_drive <= 1'b0;
                        txsh      <= {txsh[30:0], 1'b0};
                    end else if (byte_idx == 3'd0) begin
                        if (shreg[7:1] == SLV_ADR) begin
                            slv_drive <= 1'b1;
                            rd_go     <= shreg[0];
                        end else begin
                            active <= 1'b0;
                        end
                    end else if (byte_idx == 3'd1) begin
                        reg_addr  <= shreg;
                        slv_drive <= 1'b1;
                    end else begin
                        slv_drive <= 1'b1;
                        wbuf      <= {wbuf[23:0], shreg};
                        if (byte_idx == 3'd5) begin
                            mem[reg_addr] <= {wbuf[23:0], shreg};
                            wr_cnt        <= wr_cnt + 1;
                            wr_addr       <= reg_addr;
                            wr_data       <= {wbuf[23:0], shreg};
                        end
                    end
                end else if (in_ack) begin
                    in_ack   <= 1'b0;
                    bitc     <= 4'd0;
                    byte_idx <= byte_idx + 3'd1;
                    if (rd_go) begin
                        tx        <= 1'b1;
                        rd_go     <= 1'b0;
                        txsh      <= mem[reg_addr];
                        slv_drive <= ~mem[reg_addr][31];
                    end else if (tx && !m_nack) begin
                        slv_drive <= ~txsh[31];
                    end else if (tx) begin
                        slv_drive <= 1'b0;
                        tx        <= 1'b0;
                        active    <= 1'b0;
                    end else begin
                        slv_drive <= 1'b0;
                    end
                end else if (tx && bitc != 4'd0) begin
                    txsh      <= {txsh[30:0], 1'b0};
                    slv_drive <= ~txsh[30];
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] dev, input logic rw, input logic [7:0] addr, input logic [31:0] wd);
        dev_adr   = dev;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int i;
        for (i = 0; i < 6000; i++) begin
            tick();
            if (rsp_valid) break;
        end
        if (i == 6000) check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_ready(input string tag, output int waited);
        waited = 0;
        while (!cmd_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!cmd_ready) check({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    endtask

    logic [8:0] exp_q [$];

    task automatic check_frame(input string tag, input int base);
        check({tag, "_nbytes"}, 32'(mon_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < mon_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(mon_q[base + i]), 32'(exp_q[i]));
    endtask

    initial begin
        int base, s0, p0, w0, r0, k;
        int acc, rsps, ready_during, rsp1_cyc, gap;
        logic prev_ready;

        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_scl", 32'(scl_v), 32'd1);
        check("rst_sda", 32'(sda_v), 32'd1);

        // 1: write plus SCL timing
        base = mon_q.size(); s0 = n_start; p0 = n_stop; w0 = wr_cnt;
        stat_en = 1'b1;
        issue(7'h50, 1'b0, 8'h3C, 32'hDEADBEEF);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ready_low", 32'(cmd_ready), 32'd0);
        wait_rsp("wr");
        stat_en = 1'b0;
        check("wr_nack", 32'(rsp_nack), 32'd0);
        check("wr_rdata", rsp_rdata, 32'd0);
        tick();
        check("wr_rsp_pulse", 32'(rsp_valid), 32'd0);
        k = 1;
        while (!cmd_ready && k < 200) begin
            tick();
            k++;
        end
        check("wr_buf_cycles", 32'(k), 32'd32);
        check("wr_busy_end", 32'(busy), 32'd0);
        exp_q = '{{8'hA0, 1'b0}, {8'h3C, 1'b0}, {8'hDE, 1'b0}, {8'hAD, 1'b0}, {8'hBE, 1'b0}, {8'hEF, 1'b0}};
        check_frame("wr", base);
        check("wr_ram_cnt", 32'(wr_cnt - w0), 32'd1);
        check("wr_ram_addr", 32'(wr_addr), 32'h3C);
        check("wr_ram_data", wr_data, 32'hDEADBEEF);
        check("wr_starts", 32'(n_start - s0), 32'd1);
        check("wr_stops", 32'(n_stop - p0), 32'd1);
        check("t_scl_hi_min", 32'(hi_min), 32'd16);
        check("t_scl_hi_max", 32'(hi_max), 32'd16);
        check("t_scl_lo_min", 32'(lo_min), 32'd16);
        check("t_scl_lo_max", 32'(lo_max), 32'd16);
        check("t_start_hold", 32'(start_hold), 32'd8);

        // 2: read with repeated START
        base = mon_q.size(); s0 = n_start; p0 = n_stop;
        issue(7'h50, 1'b1, 8'h10, 32'h0);
        wait_rsp("rd");
        check("rd_rdata", rsp_rdata, 32'h12345678);
        check("rd_nack", 32'(rsp_nack), 32'd0);
        wait_ready("rd", k);
        exp_q = '{{8'hA0, 1'b0}, {8'h10, 1'b0}, {8'hA1, 1'b0}, {8'h12, 1'b0},
                  {8'h34, 1'b0}, {8'h56, 1'b0}, {8'h78, 1'b1}};
        check_frame("rd", base);
        check("rd_starts", 32'(n_start - s0), 32'd2);
        check("rd_stops", 32'(n_stop - p0), 32'd1);

        // 3: address NACK
        base = mon_q.size(); p0 = n_stop; w0 = wr_cnt;
        issue(7'h51, 1'b0, 8'h3C, 32'h11111111);
        wait_rsp("nk");
        check("nk_nack", 32'(rsp_nack), 32'd1);
        check("nk_rdata", rsp_rdata, 32'd0);
        wait_ready("nk", k);
        exp_q = '{{8'hA2, 1'b1}};
        check_frame("nk", base);
        check("nk_ram_cnt", 32'(wr_cnt - w0), 32'd0);
        check("nk_stops", 32'(n_stop - p0), 32'd1);

        // 4: cmd_valid held through two back-to-back writes
        w0 = wr_cnt; acc = 0; rsps = 0; ready_during = 0; rsp1_cyc = 0; gap = 0;
        dev_adr = 7'h50; cmd_rw = 1'b0; cmd_addr = 8'h20; cmd_wdata = 32'hCAFEF00D;
        cmd_valid = 1'b1;
        for (int c = 0; c < 12000 && rsps < 2; c++) begin
            prev_ready = cmd_ready;
            tick();
            if (prev_ready && cmd_valid) begin
                acc++;
                if (acc == 1) begin
                    cmd_addr  = 8'h24;
                    cmd_wdata = 32'h0BADF00D;
                end else begin
                    gap       = c - rsp1_cyc;
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                rsps++;
                if (rsps == 1) rsp1_cyc = c;
            end
            if (acc == 1 && rsps == 0 && cmd_ready) ready_during++;
        end
        cmd_valid = 1'b0;
        check("hs_accepts", 32'(acc), 32'd2);
        check("hs_rsps", 32'(rsps), 32'd2);
        check("hs_ready_during_txn", 32'(ready_during), 32'd0);
        check("hs_accept_gap", 32'(gap), 32'd33);
        check("hs_ram_cnt", 32'(wr_cnt - w0), 32'd2);
        check("hs_ram_data", wr_data, 32'h0BADF00D);
        check("hs_ram_addr", 32'(wr_addr), 32'h24);
        wait_ready("hs", k);

        // 5: reset in the middle of a data byte
        base = mon_q.size(); w0 = wr_cnt;
        issue(7'h50, 1'b0, 8'h3C, 32'h55AA55AA);
        k = 0;
        while (mon_q.size() - base < 3 && k < 3000) begin
            tick();
            k++;
        end
        check("mr_reached_data", 32'(mon_q.size() - base), 32'd3);
        repeat (130) tick();
        check("mr_busy_before", 32'(busy), 32'd1);
        r0 = n_rsp;
        rst = 1'b1;
        tick();
        check("mr_scl_rel", 32'(scl_v), 32'd1);
        check("mr_sda_rel", 32'(sda_v), 32'd1);
        check("mr_ready", 32'(cmd_ready), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (200) tick();
        check("mr_no_rsp", 32'(n_rsp - r0), 32'd0);
        check("mr_no_ram_wr", 32'(wr_cnt - w0), 32'd0);
        issue(7'h50, 1'b1, 8'h3C, 32'h0);
        wait_rsp("mr_rd");
        check("mr_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("mr_rd_nack", 32'(rsp_nack), 32'd0);
        wait_ready("mr_rd", k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
